// File: rtl/simu_commit_trace_buf.sv
// Commit trace buffer: captures up to CMT_NUM retired instructions per cycle
// into a circular buffer and presents them one at a time on a valid/ready port.
module simu_commit_trace_buf #(
  parameter int CMT_NUM   = 2,
  parameter int CPU_WIDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           trace_en,
  input  logic                           flush,
  input  logic [CMT_NUM-1:0]             cmt_valid,
  input  logic [CMT_NUM*CPU_WIDTH-1:0]   cmt_pc,
  input  logic [CMT_NUM-1:0]             cmt_rf_wen,
  input  logic [CMT_NUM*5-1:0]           cmt_rf_wnum,
  input  logic [CMT_NUM*CPU_WIDTH-1:0]   cmt_rf_wdata,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [CPU_WIDTH-1:0]           trace_pc,
  output logic                           trace_rf_wen,
  output logic [4:0]                     trace_rf_wnum,
  output logic [CPU_WIDTH-1:0]           trace_rf_wdata,
  output logic [1:0]                     trace_chan,
  output logic [31:0]                    trace_seq,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic [15:0]                    drop_cnt,
  output logic                           overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [CPU_WIDTH-1:0] mem_pc    [DEPTH];
  logic                 mem_wen   [DEPTH];
  logic [4:0]           mem_wnum  [DEPTH];
  logic [CPU_WIDTH-1:0] mem_wdata [DEPTH];
  logic [1:0]           mem_chan  [DEPTH];
  logic [31:0]          mem_seq   [DEPTH];

  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [31:0]     seq_q, seq_d;
  logic [15:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d;

  logic [CNTW-1:0]    free_slots;
  logic [CNTW-1:0]    rank [CMT_NUM];
  logic [CNTW-1:0]    nvalid, enq_n, drop_n;
  logic [CMT_NUM-1:0] take;
  logic               cap_en, deq;
  logic [16:0]        drop_sum;

  logic [AW-1:0] wr_addr [CMT_NUM];
  logic [31:0]   wr_seq  [CMT_NUM];

  assign cap_en     = trace_en && !flush;
  // Free space is judged on the registered count, so a dequeue this cycle never makes room.
  assign free_slots = CNTW'(DEPTH) - count_q;
  assign deq        = (count_q != '0) && trace_ready && !flush;

  always_comb begin
    nvalid = '0;
    enq_n  = '0;
    take   = '0;
    for (int i = 0; i < CMT_NUM; i++) begin
      rank[i] = nvalid;
      if (cap_en && cmt_valid[i]) begin
        if (nvalid < free_slots) begin
          take[i] = 1'b1;
          enq_n   = enq_n + CNTW'(1);
        end
        nvalid = nvalid + CNTW'(1);
      end
    end
    drop_n = nvalid - enq_n;
  end

  // Taken channels are packed densely from the tail in channel order.
  generate
    for (genvar gi = 0; gi < CMT_NUM; gi++) begin : g_wr
      assign wr_addr[gi] = tail_q + rank[gi][AW-1:0];
      assign wr_seq[gi]  = seq_q + 32'(rank[gi]);
    end
  endgenerate

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(drop_n);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d    = ovf_q | (drop_n != '0);
    seq_d    = seq_q + 32'(enq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq);
      tail_d  = tail_q + enq_n[AW-1:0];
      count_d = count_q + enq_n - CNTW'(deq);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < CMT_NUM; i++) begin
      if (take[i]) begin
        mem_pc[wr_addr[i]]    <= cmt_pc[i*CPU_WIDTH +: CPU_WIDTH];
        mem_wen[wr_addr[i]]   <= cmt_rf_wen[i];
        mem_wnum[wr_addr[i]]  <= cmt_rf_wnum[i*5 +: 5];
        mem_wdata[wr_addr[i]] <= cmt_rf_wdata[i*CPU_WIDTH +: CPU_WIDTH];
        mem_chan[wr_addr[i]]  <= 2'(i);
        mem_seq[wr_addr[i]]   <= wr_seq[i];
      end
    end
  end

  assign trace_valid    = (count_q != '0);
  assign trace_pc       = mem_pc[head_q];
  assign trace_rf_wen   = mem_wen[head_q];
  assign trace_rf_wnum  = mem_wnum[head_q];
  assign trace_rf_wdata = mem_wdata[head_q];
  assign trace_chan     = mem_chan[head_q];
  assign trace_seq      = mem_seq[head_q];
  assign fifo_count     = count_q;
  assign drop_cnt       = drop_q;
  assign overflow       = ovf_q;

endmodule
